// File: rtl/flappy_pkg.sv
// Shared types and geometry defaults for the flappy game blocks.
// The bird, pipe generator and collision detector all import this package.
package flappy_pkg;

  localparam int DEF_ROWS      = 16;
  localparam int DEF_COLS      = 16;
  localparam int DEF_NUM_PIPES = 4;
  localparam int DEF_GAP_H     = 4;
  localparam int DEF_BIRD_COL  = 3;

  typedef logic [$clog2(DEF_ROWS)-1:0] row_t;
  typedef logic [$clog2(DEF_COLS)-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } det_state_t;

endpackage

// File: rtl/pipe_collision_detector_if.sv
// Signal bundle between the collision detector, game control and the pipe table.
// The slave modport is the detector's view; master is the surrounding system.
interface pipe_collision_detector_if #(
  parameter int ROWS      = flappy_pkg::DEF_ROWS,
  parameter int COLS      = flappy_pkg::DEF_COLS,
  parameter int NUM_PIPES = flappy_pkg::DEF_NUM_PIPES
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(NUM_PIPES);

  logic          tick;
  logic          running;
  logic [RW-1:0] bird_row;
  logic [IW-1:0] pipe_idx;
  logic          pipe_valid;
  logic [CW-1:0] pipe_col;
  logic [RW-1:0] pipe_gap_top;
  logic          collision;
  logic          floor_hit;
  logic          busy;
  logic          overrun;

  modport slave (
    input  tick, running, bird_row, pipe_valid, pipe_col, pipe_gap_top,
    output pipe_idx, collision, floor_hit, busy, overrun
  );

  modport master (
    output tick, running, bird_row, pipe_valid, pipe_col, pipe_gap_top,
    input  pipe_idx, collision, floor_hit, busy, overrun
  );
endinterface

// File: rtl/pipe_hit_check.sv
// Combinational test of one pipe-table entry against the bird position.
// A hit means the bird sits in the pipe's column but outside its open gap.
module pipe_hit_check #(
  parameter int ROWS     = flappy_pkg::DEF_ROWS,
  parameter int COLS     = flappy_pkg::DEF_COLS,
  parameter int GAP_H    = flappy_pkg::DEF_GAP_H,
  parameter int BIRD_COL = flappy_pkg::DEF_BIRD_COL
) (
  input  logic                    i_valid,
  input  logic [$clog2(ROWS)-1:0] i_row,
  input  logic [$clog2(COLS)-1:0] i_col,
  input  logic [$clog2(ROWS)-1:0] i_gap_top,
  output logic                    o_hit
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  // One extra bit so a gap running past the floor row does not wrap to the top.
  logic [RW:0] w_gap_end;
  logic        w_above;
  logic        w_below;
  logic        w_col_match;

  assign w_gap_end   = {1'b0, i_gap_top} + (RW+1)'(GAP_H);
  assign w_above     = i_row < i_gap_top;
  assign w_below     = {1'b0, i_row} >= w_gap_end;
  assign w_col_match = i_col == CW'(BIRD_COL);
  assign o_hit       = i_valid && w_col_match && (w_above || w_below);

endmodule

// File: rtl/pipe_collision_detector.sv
// Per-tick scan of the pipe table against the bird; emits a one-cycle collision
// pulse (qualified by floor_hit) a fixed NUM_PIPES+1 cycles after the tick.
module pipe_collision_detector
  import flappy_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int NUM_PIPES = DEF_NUM_PIPES,
  parameter int GAP_H     = DEF_GAP_H,
  parameter int BIRD_COL  = DEF_BIRD_COL
) (
  input  logic                        clk,
  input  logic                        reset,
  pipe_collision_detector_if.slave    bus
);
  localparam int RW = $clog2(ROWS);
  localparam int IW = $clog2(NUM_PIPES);

  det_state_t    r_state;
  logic [IW-1:0] r_idx;
  logic          r_hit;
  logic          r_fhit;
  logic          r_coll;
  logic          r_floor;
  logic          r_ovr;
  logic [RW-1:0] r_row_q;

  det_state_t    w_state_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic          w_hit_nxt;
  logic          w_fhit_nxt;
  logic          w_coll_nxt;
  logic          w_floor_nxt;
  logic          w_ovr_nxt;
  logic          w_capture;
  logic          w_entry_hit;

  pipe_hit_check #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .GAP_H    (GAP_H),
    .BIRD_COL (BIRD_COL)
  ) u_hit_check (
    .i_valid   (bus.pipe_valid),
    .i_row     (r_row_q),
    .i_col     (bus.pipe_col),
    .i_gap_top (bus.pipe_gap_top),
    .o_hit     (w_entry_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hit_nxt   = r_hit;
    w_fhit_nxt  = r_fhit;
    w_coll_nxt  = 1'b0;
    w_floor_nxt = 1'b0;
    w_ovr_nxt   = r_ovr | (bus.tick & (r_state != IDLE));
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tick && bus.running) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_hit_nxt   = 1'b0;
          w_fhit_nxt  = bus.bird_row == RW'(ROWS-1);
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        // Game over mid-scan: drop the partial result so no stale pulse escapes.
        if (!bus.running) begin
          w_idx_nxt   = '0;
          w_hit_nxt   = 1'b0;
          w_fhit_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_hit_nxt = r_hit | w_entry_hit;
          if (r_idx == IW'(NUM_PIPES-1)) begin
            w_state_nxt = REPORT;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      REPORT: begin
        w_coll_nxt  = r_hit | r_fhit;
        w_floor_nxt = r_fhit;
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_fhit  <= 1'b0;
      r_coll  <= 1'b0;
      r_floor <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hit   <= w_hit_nxt;
      r_fhit  <= w_fhit_nxt;
      r_coll  <= w_coll_nxt;
      r_floor <= w_floor_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Captured row is pure data and only meaningful while the FSM is busy.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_row_q <= bus.bird_row;
    end
  end

  assign bus.pipe_idx  = r_idx;
  assign bus.collision = r_coll;
  assign bus.floor_hit = r_floor;
  assign bus.busy      = r_state != IDLE;
  assign bus.overrun   = r_ovr;

endmodule
